// File: rtl/usb_pd_prl_ctrl.sv
// USB Power Delivery protocol-layer controller: GoodCRC replies to received
// messages, duplicate filtering, and user transmit with GoodCRC wait and retry.
module usb_pd_prl_ctrl #(
  parameter int system_khz     = 200000,
  parameter int crc_timeout_us = 900,
  parameter int n_retry        = 2
) (
  input  logic       clock,
  input  logic       nrst,
  output logic       rx_en,
  input  logic       rx_busy,
  input  logic       rx_pkg_valid,
  input  logic       rx_crc_valid,
  input  logic [2:0] rx_msg_id,
  input  logic [2:0] rx_msg_num,
  input  logic [3:0] rx_msg_type,
  output logic       tx_start,
  output logic       tx_goodcrc,
  output logic [2:0] tx_msg_id,
  input  logic       tx_done,
  input  logic       usr_req,
  output logic       usr_ack,
  output logic       usr_done,
  output logic       usr_fail,
  output logic       rx_msg_stb
);

  localparam int t_cycles = system_khz * crc_timeout_us / 1000;
  localparam int tw = ($clog2(t_cycles) > 20) ? $clog2(t_cycles) : 20;
  localparam logic [tw-1:0] t_last = tw'(t_cycles - 1);
  localparam int rw = (n_retry < 1) ? 1 : $clog2(n_retry + 1);
  localparam logic [rw-1:0] retry_max = rw'(n_retry);

  typedef enum logic [2:0] {
    IDLE,
    RX,
    GCRC_SEND,
    TX_SEND,
    TX_WAIT
  } state_t;

  state_t        state, state_nx;
  logic          active;
  logic          gcrc_kick, gcrc_kick_nx;
  logic [2:0]    tx_id_cnt, tx_id_cnt_nx;
  logic [2:0]    hdr_id, hdr_id_nx;
  logic [2:0]    hdr_num, hdr_num_nx;
  logic [3:0]    hdr_type, hdr_type_nx;
  logic [2:0]    last_id, last_id_nx;
  logic          last_valid, last_valid_nx;
  logic [rw-1:0] retry, retry_nx;
  logic [tw-1:0] timer, timer_nx;

  logic rx_good, rx_is_gcrc, hdr_is_soft, tx_ack_ok, timeout;

  assign rx_good     = rx_pkg_valid && rx_crc_valid;
  assign rx_is_gcrc  = (rx_msg_num == 3'd0) && (rx_msg_type == 4'h1);
  assign hdr_is_soft = (hdr_num == 3'd0) && (hdr_type == 4'hD);
  assign tx_ack_ok   = rx_good && rx_is_gcrc && (rx_msg_id == tx_id_cnt);
  assign timeout     = (timer == t_last);

  // active stays low through reset and the first clock after it, which keeps
  // rx_en and any user acceptance quiet until the controller is really running
  assign rx_en      = active && (state == IDLE || state == RX || state == TX_WAIT);
  assign tx_goodcrc = (state == GCRC_SEND);
  assign tx_msg_id  = (state == GCRC_SEND) ? hdr_id : tx_id_cnt;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      active     <= 1'b0;
      gcrc_kick  <= 1'b0;
      tx_id_cnt  <= 3'd0;
      hdr_id     <= 3'd0;
      hdr_num    <= 3'd0;
      hdr_type   <= 4'd0;
      last_id    <= 3'd0;
      last_valid <= 1'b0;
      retry      <= '0;
      timer      <= '0;
    end else begin
      state      <= state_nx;
      active     <= 1'b1;
      gcrc_kick  <= gcrc_kick_nx;
      tx_id_cnt  <= tx_id_cnt_nx;
      hdr_id     <= hdr_id_nx;
      hdr_num    <= hdr_num_nx;
      hdr_type   <= hdr_type_nx;
      last_id    <= last_id_nx;
      last_valid <= last_valid_nx;
      retry      <= retry_nx;
      timer      <= timer_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    gcrc_kick_nx  = 1'b0;
    tx_id_cnt_nx  = tx_id_cnt;
    hdr_id_nx     = hdr_id;
    hdr_num_nx    = hdr_num;
    hdr_type_nx   = hdr_type;
    last_id_nx    = last_id;
    last_valid_nx = last_valid;
    retry_nx      = retry;
    timer_nx      = timer;
    tx_start      = 1'b0;
    usr_ack       = 1'b0;
    usr_done      = 1'b0;
    usr_fail      = 1'b0;
    rx_msg_stb    = 1'b0;

    case (state)
      IDLE: begin
        if (rx_busy) begin
          state_nx = RX;
        end else if (usr_req && active) begin
          usr_ack  = 1'b1;
          tx_start = 1'b1;
          retry_nx = '0;
          state_nx = TX_SEND;
        end
      end

      RX: begin
        if (rx_good) begin
          if (rx_is_gcrc) begin
            state_nx = IDLE;
          end else begin
            hdr_id_nx    = rx_msg_id;
            hdr_num_nx   = rx_msg_num;
            hdr_type_nx  = rx_msg_type;
            gcrc_kick_nx = 1'b1;
            state_nx     = GCRC_SEND;
          end
        end else if (rx_pkg_valid || !rx_busy) begin
          state_nx = IDLE;
        end
      end

      // Soft_Reset is always delivered and restarts both MessageID sequences
      GCRC_SEND: begin
        tx_start = gcrc_kick;
        if (tx_done) begin
          rx_msg_stb    = hdr_is_soft || !last_valid || (hdr_id != last_id);
          last_id_nx    = hdr_id;
          last_valid_nx = !hdr_is_soft;
          if (hdr_is_soft) tx_id_cnt_nx = 3'd0;
          state_nx = IDLE;
        end
      end

      TX_SEND: begin
        if (tx_done) begin
          timer_nx = '0;
          state_nx = TX_WAIT;
        end
      end

      TX_WAIT: begin
        timer_nx = timer + 1'b1;
        if (tx_ack_ok) begin
          usr_done     = 1'b1;
          tx_id_cnt_nx = tx_id_cnt + 3'd1;
          state_nx     = IDLE;
        end else if (timeout) begin
          if (retry < retry_max) begin
            retry_nx = retry + 1'b1;
            tx_start = 1'b1;
            state_nx = TX_SEND;
          end else begin
            usr_fail = 1'b1;
            state_nx = IDLE;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_pd_prl_ctrl.sv
// Directed bench for usb_pd_prl_ctrl: pulse outputs are matched against a
// queue of expected events pushed as each stimulus step is driven.
module tb_usb_pd_prl_ctrl;

  localparam int t_cyc = 100;

  localparam logic [3:0] k_ack   = 4'd1;
  localparam logic [3:0] k_start = 4'd2;
  localparam logic [3:0] k_done  = 4'd3;
  localparam logic [3:0] k_fail  = 4'd4;
  localparam logic [3:0] k_stb   = 4'd5;

  logic       clock = 1'b0;
  logic       nrst  = 1'b1;
  logic       rx_en;
  logic       rx_busy;
  logic       rx_pkg_valid;
  logic       rx_crc_valid;
  logic [2:0] rx_msg_id;
  logic [2:0] rx_msg_num;
  logic [3:0] rx_msg_type;
  logic       tx_start;
  logic       tx_goodcrc;
  logic [2:0] tx_msg_id;
  logic       tx_done;
  logic       usr_req;
  logic       usr_ack;
  logic       usr_done;
  logic       usr_fail;
  logic       rx_msg_stb;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seen[$];

  usb_pd_prl_ctrl #(
    .system_khz    (1000),
    .crc_timeout_us(100),
    .n_retry       (2)
  ) dut (
    .clock       (clock),
    .nrst        (nrst),
    .rx_en       (rx_en),
    .rx_busy     (rx_busy),
    .rx_pkg_valid(rx_pkg_valid),
    .rx_crc_valid(rx_crc_valid),
    .rx_msg_id   (rx_msg_id),
    .rx_msg_num  (rx_msg_num),
    .rx_msg_type (rx_msg_type),
    .tx_start    (tx_start),
    .tx_goodcrc  (tx_goodcrc),
    .tx_msg_id   (tx_msg_id),
    .tx_done     (tx_done),
    .usr_req     (usr_req),
    .usr_ack     (usr_ack),
    .usr_done    (usr_done),
    .usr_fail    (usr_fail),
    .rx_msg_stb  (rx_msg_stb)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ev(input logic [3:0] kind, input logic gc, input logic [2:0] id);
    return {kind, gc, id};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every pulse seen at a falling edge must match the oldest pending expectation
  always @(negedge clock) begin
    seen.delete();
    if (usr_ack)    seen.push_back(ev(k_ack, 1'b0, 3'd0));
    if (tx_start)   seen.push_back(ev(k_start, tx_goodcrc, tx_msg_id));
    if (usr_done)   seen.push_back(ev(k_done, 1'b0, 3'd0));
    if (usr_fail)   seen.push_back(ev(k_fail, 1'b0, 3'd0));
    if (rx_msg_stb) seen.push_back(ev(k_stb, 1'b0, 3'd0));
    foreach (seen[i]) begin
      if (exp_q.size() == 0) checkOutput("unexpected_event", 32'(seen[i]), 32'd0);
      else checkOutput("event", 32'(seen[i]), 32'(exp_q.pop_front()));
    end
  end

  task automatic step_clock();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step_clock();
  endtask

  task automatic send_tx_done();
    tx_done = 1'b1;
    step_clock();
    tx_done = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] id, input logic [2:0] num, input logic [3:0] typ,
                               input logic valid, input logic crc);
    rx_busy = 1'b1;
    step_clock();
    step_clock();
    rx_msg_id    = id;
    rx_msg_num   = num;
    rx_msg_type  = typ;
    rx_pkg_valid = valid;
    rx_crc_valid = crc;
    step_clock();
    rx_pkg_valid = 1'b0;
    rx_crc_valid = 1'b0;
    rx_busy      = 1'b0;
    step_clock();
  endtask

  task automatic user_tx(input logic [2:0] id);
    exp_q.push_back(ev(k_ack, 1'b0, 3'd0));
    exp_q.push_back(ev(k_start, 1'b0, id));
    exp_q.push_back(ev(k_done, 1'b0, 3'd0));
    usr_req = 1'b1;
    step_clock();
    usr_req = 1'b0;
    step_clock();
    send_tx_done();
    step_clock();
    applyStimulus(id, 3'd0, 4'h1, 1'b1, 1'b1);
    idle(2);
  endtask

  initial begin
    rx_busy      = 1'b1;
    rx_pkg_valid = 1'b0;
    rx_crc_valid = 1'b0;
    rx_msg_id    = 3'd0;
    rx_msg_num   = 3'd0;
    rx_msg_type  = 4'd0;
    tx_done      = 1'b0;
    usr_req      = 1'b1;

    // Reset with requests pending: everything must stay quiet
    #2 nrst = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_outputs",
                32'({rx_en, tx_start, tx_goodcrc, tx_msg_id, usr_ack, usr_done, usr_fail, rx_msg_stb}), 32'd0);
    usr_req = 1'b0;
    rx_busy = 1'b0;
    step_clock();
    nrst = 1'b1;
    @(negedge clock);
    checkOutput("rx_en_before_first_clock", 32'(rx_en), 32'd0);
    step_clock();
    @(negedge clock);
    checkOutput("rx_en_idle", 32'(rx_en), 32'd1);
    step_clock();

    // New message gets GoodCRC and is delivered; its repeat is only acknowledged
    exp_q.push_back(ev(k_start, 1'b1, 3'd3));
    exp_q.push_back(ev(k_stb, 1'b0, 3'd0));
    applyStimulus(3'd3, 3'd1, 4'h1, 1'b1, 1'b1);
    @(negedge clock);
    checkOutput("rx_en_gcrc", 32'(rx_en), 32'd0);
    checkOutput("goodcrc_flag", 32'(tx_goodcrc), 32'd1);
    step_clock();
    send_tx_done();
    idle(3);
    exp_q.push_back(ev(k_start, 1'b1, 3'd3));
    applyStimulus(3'd3, 3'd1, 4'h1, 1'b1, 1'b1);
    step_clock();
    send_tx_done();
    idle(3);

    // Bad CRC, busy without packet, and a stray GoodCRC: no response at all
    applyStimulus(3'd5, 3'd1, 4'h2, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("bad_crc_no_goodcrc", 32'({rx_en, tx_goodcrc}), 32'b10);
    step_clock();
    applyStimulus(3'd0, 3'd0, 4'h0, 1'b0, 1'b0);
    applyStimulus(3'd2, 3'd0, 4'h1, 1'b1, 1'b1);
    idle(3);

    // First user transmit, with a wrong-id GoodCRC and a non-GoodCRC ignored
    exp_q.push_back(ev(k_ack, 1'b0, 3'd0));
    exp_q.push_back(ev(k_start, 1'b0, 3'd0));
    usr_req = 1'b1;
    step_clock();
    usr_req = 1'b0;
    @(negedge clock);
    checkOutput("rx_en_tx_send", 32'(rx_en), 32'd0);
    step_clock();
    send_tx_done();
    @(negedge clock);
    checkOutput("rx_en_tx_wait", 32'(rx_en), 32'd1);
    step_clock();
    applyStimulus(3'd5, 3'd0, 4'h1, 1'b1, 1'b1);
    applyStimulus(3'd0, 3'd1, 4'h2, 1'b1, 1'b1);
    exp_q.push_back(ev(k_done, 1'b0, 3'd0));
    applyStimulus(3'd0, 3'd0, 4'h1, 1'b1, 1'b1);
    idle(2);

    // Walk the MessageID up to 7 and through the wrap to 0
    for (int i = 1; i < 8; i++) user_tx(3'(i));
    user_tx(3'd0);

    // No GoodCRC ever: two retries spaced by the timeout, then failure
    exp_q.push_back(ev(k_ack, 1'b0, 3'd0));
    exp_q.push_back(ev(k_start, 1'b0, 3'd1));
    usr_req = 1'b1;
    step_clock();
    usr_req = 1'b0;
    step_clock();
    for (int r = 0; r < 3; r++) begin
      send_tx_done();
      repeat (t_cyc - 2) step_clock();
      @(negedge clock);
      checkOutput("retry_early", 32'(tx_start | usr_fail), 32'd0);
      if (r < 2) exp_q.push_back(ev(k_start, 1'b0, 3'd1));
      else exp_q.push_back(ev(k_fail, 1'b0, 3'd0));
      step_clock();
      @(negedge clock);
      if (r < 2) checkOutput("retry_start", 32'(tx_start), 32'd1);
      else checkOutput("retry_fail", 32'(usr_fail), 32'd1);
      step_clock();
    end
    idle(3);

    // GoodCRC landing on the last timer cycle wins over the retry
    exp_q.push_back(ev(k_ack, 1'b0, 3'd0));
    exp_q.push_back(ev(k_start, 1'b0, 3'd1));
    usr_req = 1'b1;
    step_clock();
    usr_req = 1'b0;
    step_clock();
    send_tx_done();
    repeat (t_cyc - 1) step_clock();
    exp_q.push_back(ev(k_done, 1'b0, 3'd0));
    rx_msg_id    = 3'd1;
    rx_msg_num   = 3'd0;
    rx_msg_type  = 4'h1;
    rx_pkg_valid = 1'b1;
    rx_crc_valid = 1'b1;
    @(negedge clock);
    checkOutput("edge_success", 32'({usr_done, tx_start}), 32'b10);
    step_clock();
    rx_pkg_valid = 1'b0;
    rx_crc_valid = 1'b0;
    idle(3);

    // Receive and user request in the same cycle: receive is served first
    exp_q.push_back(ev(k_start, 1'b1, 3'd4));
    exp_q.push_back(ev(k_stb, 1'b0, 3'd0));
    exp_q.push_back(ev(k_ack, 1'b0, 3'd0));
    exp_q.push_back(ev(k_start, 1'b0, 3'd2));
    exp_q.push_back(ev(k_done, 1'b0, 3'd0));
    usr_req = 1'b1;
    applyStimulus(3'd4, 3'd1, 4'h2, 1'b1, 1'b1);
    send_tx_done();
    step_clock();
    usr_req = 1'b0;
    step_clock();
    send_tx_done();
    step_clock();
    applyStimulus(3'd2, 3'd0, 4'h1, 1'b1, 1'b1);
    idle(3);

    // Soft_Reset restarts transmit ids and forgets the last received id
    exp_q.push_back(ev(k_start, 1'b1, 3'd6));
    exp_q.push_back(ev(k_stb, 1'b0, 3'd0));
    applyStimulus(3'd6, 3'd0, 4'hD, 1'b1, 1'b1);
    step_clock();
    send_tx_done();
    idle(2);
    user_tx(3'd0);
    exp_q.push_back(ev(k_start, 1'b1, 3'd6));
    exp_q.push_back(ev(k_stb, 1'b0, 3'd0));
    applyStimulus(3'd6, 3'd1, 4'h2, 1'b1, 1'b1);
    step_clock();
    send_tx_done();
    idle(2);

    // Reset while the GoodCRC start is on the wire
    rx_busy = 1'b1;
    step_clock();
    step_clock();
    rx_msg_id    = 3'd5;
    rx_msg_num   = 3'd1;
    rx_msg_type  = 4'h2;
    rx_pkg_valid = 1'b1;
    rx_crc_valid = 1'b1;
    step_clock();
    rx_pkg_valid = 1'b0;
    rx_crc_valid = 1'b0;
    rx_busy      = 1'b0;
    #1;
    checkOutput("gcrc_start_before_reset", 32'(tx_start), 32'd1);
    nrst = 1'b0;
    #1;
    checkOutput("reset_drops_start", 32'(tx_start), 32'd0);
    checkOutput("reset_outputs_mid",
                32'({rx_en, tx_start, tx_goodcrc, tx_msg_id, usr_ack, usr_done, usr_fail, rx_msg_stb}), 32'd0);
    step_clock();
    step_clock();
    nrst = 1'b1;
    idle(5);
    user_tx(3'd0);
    idle(3);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
